// File: rtl/hazard_control_if.sv
// hazard_control_if: ID/EX hazard inputs and pipeline write/flush controls
interface hazard_control_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) ();
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  branch_taken;
  logic                  dmem_busy;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_write;
  logic                  idex_bubble;
  logic                  stall;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      load_use_events;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rd,
           ex_mem_read, branch_taken, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, stall,
           stall_cycles, load_use_events
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rd,
           ex_mem_read, branch_taken, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, stall,
           stall_cycles, load_use_events
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, memory freeze and branch flush control with perf counters
module hazard_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_control_if.slave bus
);
  typedef enum logic {RUN, LOAD_STALL} state_t;
  state_t state;
  logic [2:0] cnt;
  logic hit, ls, busy, br, stall;
  logic [CNT_W-1:0] stall_cycles, load_use_events;
  assign hit = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != REG_ADDR_W'(0)) &
               ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) | (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
  assign busy = bus.dmem_busy;
  assign br = bus.branch_taken;
  assign ls = (state == LOAD_STALL) | hit;
  // Priority: reset, freeze, branch flush, load stall, normal; all combinational so the stall has no added latency
  always_comb begin
    bus.pc_write    = rst_n & ~busy & (br | ~ls);
    bus.ifid_write  = rst_n & ~busy & (br | ~ls);
    bus.ifid_flush  = ~rst_n | (~busy & br);
    bus.idex_write  = rst_n & ~busy;
    bus.idex_bubble = ~rst_n | (~busy & (br | ls));
    stall           = rst_n & (busy | (~br & ls));
  end
  assign bus.stall = stall;
  assign bus.stall_cycles = stall_cycles;
  assign bus.load_use_events = load_use_events;
  // Stall FSM with latency down-counter and saturating performance counters; a freeze holds everything but stall_cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= 3'd0;
      stall_cycles <= '0;
      load_use_events <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (!busy) begin
        if (br) begin
          state <= RUN;
          cnt <= 3'd0;
        end else if (state == RUN) begin
          if (hit) begin
            if (load_use_events != '1) load_use_events <= load_use_events + 1'b1;
            if (LOAD_LAT > 1) begin
              state <= LOAD_STALL;
              cnt <= 3'(LOAD_LAT - 1);
            end
          end
        end else begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RUN;
        end
      end
    end
  end
endmodule
